// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the program loader
package cpu_pkg;

    localparam int INST_W           = 32;
    localparam int IM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        HOLD,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - instruction stream in, Inst_Mem write port out
interface prog_loader_if #(
    parameter int IM_AW = 8
);
    import cpu_pkg::*;

    logic              in_valid;
    logic [INST_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              im_we;
    logic [IM_AW-1:0]  im_addr;
    logic [INST_W-1:0] im_wdata;

    // Loader side: consumes the stream, drives the memory write port
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, im_we, im_addr, im_wdata
    );

    // Host side: produces the stream, observes the memory writes
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/rst_hold_cnt.sv
// rtl/rst_hold_cnt.sv - loadable down-counter with zero flag
module rst_hold_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams an instruction image into Inst_Mem and sequences CPU reset
module prog_loader
    import cpu_pkg::*;
#(
    parameter int IM_DEPTH = IM_DEPTH_DEFAULT,
    parameter int IM_AW    = $clog2(IM_DEPTH),
    parameter int RST_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           halt,
    prog_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           busy,
    output logic           halted,
    output logic           err_ovf,
    output logic [IM_AW:0] word_cnt
);

    localparam int CW = IM_AW + 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    // word_cnt doubles as the write pointer; this is the index of the last slot
    localparam logic [CW-1:0] LAST_IDX = CW'(IM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              im_we_q, im_we_d;
    logic [IM_AW-1:0]  im_addr_q, im_addr_d;
    logic [INST_W-1:0] im_wdata_q, im_wdata_d;
    logic              halt_prev_q, halt_prev_d;
    logic              in_ready;
    logic              beat;
    logic              hold_load;
    logic              hold_en;
    logic              hold_zero;

    assign in_ready = (state_q == LOAD) || (state_q == DRAIN);
    assign beat     = bus.in_valid && in_ready;

    // Next-state, write-port and bookkeeping logic
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        err_ovf_d   = err_ovf_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        halt_prev_d = halt;
        hold_load   = 1'b0;
        hold_en     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    err_ovf_d  = 1'b0;
                end
            end
            LOAD: begin
                if (beat) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = word_cnt_q[IM_AW-1:0];
                    im_wdata_d = bus.in_data;
                    word_cnt_d = word_cnt_q + CW'(1);
                    if (bus.in_last) begin
                        state_d   = HOLD;
                        hold_load = 1'b1;
                    end else if (word_cnt_q == LAST_IDX) begin
                        // Memory is full but the image continues: swallow the rest
                        state_d   = DRAIN;
                        err_ovf_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat && bus.in_last) begin
                    state_d   = HOLD;
                    hold_load = 1'b1;
                end
            end
            HOLD: begin
                if (hold_zero) begin
                    state_d = RUN;
                end else begin
                    hold_en = 1'b1;
                end
            end
            RUN: begin
                // Edge, not level: a halt left high from before RUN is not a new halt
                if (halt && !halt_prev_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            err_ovf_q   <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            halt_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            err_ovf_q   <= err_ovf_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            halt_prev_q <= halt_prev_d;
        end
    end

    // Loaded on entry to HOLD so HOLD lasts exactly RST_HOLD cycles
    rst_hold_cnt #(
        .W(HW)
    ) u_rst_hold_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .load    (hold_load),
        .load_val(HW'(RST_HOLD - 1)),
        .en      (hold_en),
        .zero    (hold_zero)
    );

    assign bus.in_ready = in_ready;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_rst      = (state_q != RUN) && (state_q != DONE);
    assign busy         = (state_q == LOAD) || (state_q == DRAIN) || (state_q == HOLD);
    assign halted       = (state_q == DONE);
    assign err_ovf      = err_ovf_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed vector bench for prog_loader
module tb_prog_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = AW + 1;
    localparam int HOLD  = 4;
    localparam int OW    = 2 + AW + 32 + 4 + CW;
    localparam logic [31:0] DA = 32'hA000_0000;
    localparam logic [31:0] DB = 32'hB000_00B0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          cpu_rst, busy, halted, err_ovf;
    logic [AW:0]   word_cnt;
    int            n_run = 0;
    int            n_fail = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    typedef struct {
        logic          st, v, l, h;
        logic [31:0]   d;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t tbl[$];

    prog_loader_if #(.IM_AW(AW)) bus ();

    prog_loader #(
        .IM_DEPTH(DEPTH),
        .IM_AW   (AW),
        .RST_HOLD(HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .halt    (halt),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .halted  (halted),
        .err_ovf (err_ovf),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wa.push_back(bus.im_addr);
            wd.push_back(bus.im_wdata);
        end
    end

    function automatic logic [OW-1:0] outs();
        return {bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata,
                cpu_rst, busy, halted, err_ovf, word_cnt};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int st, input int v, input logic [31:0] d, input int l, input int h,
                       input int rdy, input int we, input int a, input logic [31:0] wdat,
                       input int cr, input int bz, input int hl, input int er, input int wc);
        vec_t t;
        t.st  = 1'(st);
        t.v   = 1'(v);
        t.d   = d;
        t.l   = 1'(l);
        t.h   = 1'(h);
        t.exp = {1'(rdy), 1'(we), AW'(a), wdat, 1'(cr), 1'(bz), 1'(hl), 1'(er), CW'(wc)};
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        wa.delete();
        wd.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cpu_rst && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        tick();
        tick();
        chk("reset_values", outs(), {2'b00, AW'(0), 32'h0, 4'b1000, CW'(0)});
        rst = 1'b1;
        tick();

        // Per-cycle vectors: load, HOLD timing, RUN/DONE, reload, ignored start/halt
        add(1, 1, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 32'h0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, DA + i, 0, 0, 1, 1, i, DA + i, 1, 1, 0, 0, i + 1);
        add(0, 1, DA + 4, 1, 0, 0, 1, 4, DA + 4, 1, 1, 0, 0, 5);
        add(0, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 1, 1, 0, 0, 5);
        add(0, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 1, 1, 0, 0, 5);
        add(1, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 1, 1, 0, 0, 5);
        add(0, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 0, 0, 0, 0, 5);
        add(1, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 0, 0, 0, 0, 5);
        add(0, 0, 32'h0, 0, 1, 0, 0, 4, DA + 4, 0, 0, 1, 0, 5);
        add(0, 0, 32'h0, 0, 0, 0, 0, 4, DA + 4, 0, 0, 1, 0, 5);
        add(1, 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 4, DA + 4, 1, 1, 0, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, 0, 4, DA + 4, 1, 1, 0, 0, 0);
        add(0, 0, 32'h0, 0, 0, 1, 0, 4, DA + 4, 1, 1, 0, 0, 0);
        add(0, 1, DB, 1, 0, 0, 1, 0, DB, 1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            add(0, 0, 32'h0, 0, 0, 0, 0, 0, DB, 1, 1, 0, 0, 1);
        add(0, 0, 32'h0, 0, 0, 0, 0, 0, DB, 0, 0, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st;
            bus.in_valid = tbl[i].v;
            bus.in_data = tbl[i].d;
            bus.in_last = tbl[i].l;
            halt = tbl[i].h;
            tick();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        start = 1'b0;
        halt = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;

        // in_valid toggling: only accepted beats are written, in order
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(32'hE000_0000 + i, i == 4);
            if (i < 4) tick();
        end
        wait_run(n);
        chk("t2_release_delay", n, 4);
        chk("t2_nwrites", wa.size(), 5);
        for (int i = 0; i < wa.size() && i < 5; i++) begin
            chk($sformatf("t2_addr%0d", i), wa[i], i);
            chk($sformatf("t2_data%0d", i), wd[i], 32'hE000_0000 + i);
        end
        chk("t2_word_cnt", word_cnt, 5);

        // Overflow: 11 words into 8 slots
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i >= 8) chk($sformatf("t3_drain_ready%0d", i), bus.in_ready, 1);
            send(32'hF000_0000 + i, i == 10);
        end
        halt = 1'b1;
        wait_run(n);
        chk("t3_release_delay", n, 4);
        tick();
        tick();
        chk("t3_halt_high_at_entry", halted, 0);
        chk("t3_err_ovf", err_ovf, 1);
        chk("t3_word_cnt", word_cnt, 8);
        chk("t3_nwrites", wa.size(), 8);
        for (int i = 0; i < wa.size() && i < 8; i++) begin
            chk($sformatf("t3_addr%0d", i), wa[i], i);
            chk($sformatf("t3_data%0d", i), wd[i], 32'hF000_0000 + i);
        end
        halt = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3_halted", {halted, cpu_rst}, 2'b10);

        // Reset in the middle of a load
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hC000_0000 + i, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_async_reset", outs(), {2'b00, AW'(0), 32'h0, 4'b1000, CW'(0)});
        bus.in_valid = 1'b1;
        bus.in_data = 32'hC000_00FF;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_nwrites_after_reset", wa.size(), 3);
        chk("t5_idle_ready_rst", {bus.in_ready, cpu_rst, word_cnt}, {2'b01, CW'(0)});
        bus.in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(32'hC000_0009, 1'b1);
        tick();
        chk("t5_reload_nwrites", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("t5_reload_addr", wa[3], 0);
            chk("t5_reload_data", wd[3], 32'hC000_0009);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
